// File: rtl/mem_arbiter.sv
// Two-requester arbiter that serialises icache reads and dcache reads/writes onto one RAM port.
// Dcache wins contention, but the icache is forced a grant after DSTREAK_MAX contended dcache grants.
module mem_arbiter #(
  parameter int unsigned DSTREAK_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [3:0] DMAX       = 4'(DSTREAK_MAX);

  state_t     r_state;
  logic [3:0] r_dstreak;
  logic       w_dreq;
  logic       w_access;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == RAM_ACCESS);

  // Grant state and contended-dcache streak; arbitration only happens in IDLE
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_dstreak <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dreq && !iREN) begin
            r_state   <= DSERV;
            r_dstreak <= 4'd0;
          end else if (iREN && !w_dreq) begin
            r_state   <= ISERV;
            r_dstreak <= 4'd0;
          end else if (iREN && w_dreq) begin
            // Contended: the streak never passes DMAX, so the increment saturates there
            if (r_dstreak < DMAX) begin
              r_state   <= DSERV;
              r_dstreak <= r_dstreak + 4'd1;
            end else begin
              r_state   <= ISERV;
              r_dstreak <= 4'd0;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        ISERV: begin
          if (!iREN || w_access) begin
            r_state <= IDLE;
          end else begin
            r_state <= ISERV;
          end
        end
        DSERV: begin
          if (!w_dreq || w_access) begin
            r_state <= IDLE;
          end else begin
            r_state <= DSERV;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_dstreak <= 4'd0;
        end
      endcase
    end
  end

  // RAM port and requester responses decoded from the grant; reset forces IDLE so these drop at once
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = 32'd0;
    dload    = 32'd0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    case (r_state)
      ISERV: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        if (iREN && w_access) begin
          iwait = 1'b0;
        end else begin
          iwait = 1'b1;
        end
      end
      DSERV: begin
        ramaddr = daddr;
        dload   = ramload;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else if (dREN) begin
          ramREN = 1'b1;
        end else begin
          ramREN = 1'b0;
        end
        if (w_dreq && w_access) begin
          dwait = 1'b0;
        end else begin
          dwait = 1'b1;
        end
      end
      default: begin
        iwait = 1'b1;
        dwait = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, icache read, dcache write priority, abort, ERROR retry,
// starvation bound and asynchronous reset during a write.
module tb_mem_arbiter;

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int n_cmp;
  int n_err;

  logic [7:0] exp_grant [0:9];
  logic [7:0] obs_grant;

  mem_arbiter #(.DSTREAK_MAX(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge, where inputs are changed
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_grant = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44, 8'h44, 8'h44, 8'h44, 8'h49};

    // Reset with requests asserted
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b1;
    daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = FREE;
    #3;
    check_eq("rst_ramREN", 32'(ramREN), 32'd0);
    check_eq("rst_ramWEN", 32'(ramWEN), 32'd0);
    check_eq("rst_iwait",  32'(iwait),  32'd1);
    check_eq("rst_dwait",  32'(dwait),  32'd1);
    check_eq("rst_ramaddr", ramaddr, 32'd0);
    step;
    iREN = 1'b0; dWEN = 1'b0;
    #2 nRST = 1'b1;
    step;
    step;
    check_eq("idle_ramREN", 32'(ramREN), 32'd0);
    check_eq("idle_iwait",  32'(iwait),  32'd1);
    check_eq("idle_dwait",  32'(dwait),  32'd1);

    // Icache read: BUSY twice, then ACCESS
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; #1;
    check_eq("ird_arb_ramREN", 32'(ramREN), 32'd0);
    check_eq("ird_arb_iwait",  32'(iwait),  32'd1);
    step; #1;
    check_eq("ird_c2_ramREN",  32'(ramREN), 32'd1);
    check_eq("ird_c2_ramaddr", ramaddr, 32'h40);
    check_eq("ird_c2_iwait",   32'(iwait), 32'd1);
    step; #1;
    check_eq("ird_c3_iwait",   32'(iwait), 32'd1);
    step;
    ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    check_eq("ird_acc_iwait", 32'(iwait), 32'd0);
    check_eq("ird_acc_iload", iload, 32'hDEADBEEF);
    check_eq("ird_acc_dwait", 32'(dwait), 32'd1);
    step;
    iREN = 1'b0; ramstate = FREE; #1;
    check_eq("ird_post_ramREN", 32'(ramREN), 32'd0);
    check_eq("ird_post_iload",  iload, 32'd0);

    // Dcache write beats a simultaneous icache read
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; dWEN = 1'b1;
    daddr = 32'h100; dstore = 32'h12345678; ramstate = BUSY;
    step; #1;
    check_eq("dwr_ramWEN",   32'(ramWEN), 32'd1);
    check_eq("dwr_ramREN",   32'(ramREN), 32'd0);
    check_eq("dwr_ramstore", ramstore, 32'h12345678);
    check_eq("dwr_ramaddr",  ramaddr, 32'h100);
    check_eq("dwr_iwait",    32'(iwait), 32'd1);
    step;
    ramstate = ACCESS; #1;
    check_eq("dwr_acc_dwait", 32'(dwait), 32'd0);
    check_eq("dwr_acc_iwait", 32'(iwait), 32'd1);
    check_eq("dwr_acc_iload", iload, 32'd0);
    step;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;

    // Abort: dREN dropped while RAM is BUSY
    step;
    dREN = 1'b1; daddr = 32'h200; ramstate = BUSY;
    step; #1;
    check_eq("abt_ramREN",   32'(ramREN), 32'd1);
    check_eq("abt_ramstore", ramstore, 32'd0);
    check_eq("abt_dwait",    32'(dwait), 32'd1);
    step;
    dREN = 1'b0; #1;
    check_eq("abt_drop_dwait",  32'(dwait),  32'd1);
    check_eq("abt_drop_ramREN", 32'(ramREN), 32'd0);
    step;
    // Back in IDLE: a fresh request with ACCESS showing must still see one arbitration cycle
    dREN = 1'b1; daddr = 32'h300; ramstate = ACCESS; #1;
    check_eq("abt_idle_dwait",  32'(dwait),  32'd1);
    check_eq("abt_idle_ramREN", 32'(ramREN), 32'd0);

    // ERROR for three cycles, then ACCESS
    step;
    ramstate = ERROR; #1;
    check_eq("err_c1_dwait",  32'(dwait),  32'd1);
    check_eq("err_c1_ramREN", 32'(ramREN), 32'd1);
    step; #1;
    check_eq("err_c2_dwait", 32'(dwait), 32'd1);
    step; #1;
    check_eq("err_c3_dwait", 32'(dwait), 32'd1);
    step;
    ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
    check_eq("err_acc_dwait", 32'(dwait), 32'd0);
    check_eq("err_acc_dload", dload, 32'hCAFEF00D);
    check_eq("err_acc_iload", iload, 32'd0);
    step;
    dREN = 1'b0; ramstate = FREE;
    step;

    // Starvation bound: both request continuously, RAM BUSY one cycle then ACCESS
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h400; ramstate = FREE;
    for (int g = 0; g < 10; g++) begin
      step;
      ramstate = BUSY; #1;
      check_eq($sformatf("stv_busy_waits_%0d", g), {30'd0, iwait, dwait}, 32'd3);
      step;
      ramstate = ACCESS; #1;
      if (!iwait && dwait) begin
        obs_grant = 8'h49;
      end else if (!dwait && iwait) begin
        obs_grant = 8'h44;
      end else begin
        obs_grant = 8'h3F;
      end
      check_eq($sformatf("stv_grant_%0d", g), 32'(obs_grant), 32'(exp_grant[g]));
      step;
      ramstate = FREE; #1;
    end

    // Asynchronous reset during a dcache write
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b1; daddr = 32'h500; dstore = 32'hA5A5A5A5; ramstate = BUSY;
    step; #1;
    check_eq("mrst_pre_ramWEN", 32'(ramWEN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check_eq("mrst_ramWEN",  32'(ramWEN), 32'd0);
    check_eq("mrst_ramaddr", ramaddr, 32'd0);
    check_eq("mrst_dwait",   32'(dwait), 32'd1);
    dWEN = 1'b0; iREN = 1'b1; iaddr = 32'h84;
    step;
    #2 nRST = 1'b1;
    step; #1;
    check_eq("mrst_igrant_ramREN",  32'(ramREN), 32'd1);
    check_eq("mrst_igrant_ramaddr", ramaddr, 32'h84);
    check_eq("mrst_igrant_dwait",   32'(dwait), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
